// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state and lengthens the frame by one bit.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } tx_state_e;

    localparam int unsigned BAUD_DIV_DEFAULT = 10416;
    localparam int unsigned DATA_BITS        = 8;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = DATA_BITS + 3;
`else
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers are AW bits wide, so natural overflow gives the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: queued bytes leave as 8N1 frames, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_status,
    output logic       fifo_full,
    output logic       overflow,
    output logic       PC_Uart_txd
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic          fifo_pop;
    logic          fifo_full_w;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          baud_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (reset),
        .push_i  (tx_enable),
        .pop_i   (fifo_pop),
        .data_i  (tx_data),
        .data_o  (fifo_dout),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_done   = (baud_cnt_q == BAUD_LAST);
    assign tx_status   = (state_q == ST_IDLE) && (fifo_count == '0);
    assign fifo_full   = fifo_full_w;
    assign overflow    = overflow_q;
    assign PC_Uart_txd = txd_q;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                txd_d      = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    txd_d    = 1'b0;
                    state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    txd_d      = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = ST_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        // Next bit is driven straight from shift_q[1] so txd stays registered.
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    txd_d      = 1'b1;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        txd_d    = 1'b0;
                        state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                    end else begin
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                baud_cnt_d = '0;
                txd_d      = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase

        overflow_d = overflow_q | (tx_enable & fifo_full_w & ~fifo_pop);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (BAUD_DIV=4, FIFO_DEPTH=8).
// A line monitor decodes frames; tasks compare them against an expected-byte queue.
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int unsigned B     = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned F     = FRAME_BITS * B;

    logic       sysclk    = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] tx_data   = '0;
    logic       tx_enable = 1'b0;
    logic       tx_status;
    logic       fifo_full;
    logic       overflow;
    logic       PC_Uart_txd;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    typedef struct {
        logic [7:0]  data;
        bit          ok;
        int unsigned start;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];
    int         rd_idx = 0;

    uart_tx_buffered #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_status   (tx_status),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .PC_Uart_txd (PC_Uart_txd)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Line monitor: every cycle of a bit must match its first cycle, start=0, stop=1.
    bit          rx_busy = 1'b0;
    int unsigned rx_cnt  = 0;
    int unsigned rx_k    = 0;
    logic        rx_cur  = 1'b1;
    frame_t      rx_f;

    always @(negedge sysclk) begin
        if (reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (PC_Uart_txd === 1'b0) begin
                rx_busy    = 1'b1;
                rx_cnt     = 0;
                rx_cur     = 1'b0;
                rx_f.data  = '0;
                rx_f.ok    = 1'b1;
                rx_f.start = cyc;
            end
        end else begin
            rx_cnt = rx_cnt + 1;
            rx_k   = rx_cnt / B;
            if (rx_cnt % B == 0) begin
                rx_cur = PC_Uart_txd;
                if (rx_k >= 1 && rx_k <= 8) rx_f.data[rx_k-1] = PC_Uart_txd;
`ifdef UART_TX_PARITY_EN
                if (rx_k == 9 && PC_Uart_txd !== ^rx_f.data) rx_f.ok = 1'b0;
`endif
                if (rx_k == FRAME_BITS - 1 && PC_Uart_txd !== 1'b1) rx_f.ok = 1'b0;
            end else if (PC_Uart_txd !== rx_cur) begin
                rx_f.ok = 1'b0;
            end
            if (rx_cnt == F - 1) begin
                rx_q.push_back(rx_f);
                rx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_until(input int unsigned e);
        while (cyc < e) @(negedge sysclk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        tx_enable = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    // Writes n bytes on consecutive edges; the first n_accept go to the scoreboard.
    task automatic write_burst(input logic [7:0] base, input int n, input int n_accept,
                               output int unsigned first_edge);
        first_edge = 0;
        for (int i = 0; i < n; i++) begin
            tx_enable = 1'b1;
            tx_data   = 8'(base + i * 17);
            if (i < n_accept) exp_q.push_back(tx_data);
            @(negedge sysclk);
            if (i == 0) first_edge = cyc;
        end
        tx_enable = 1'b0;
    endtask

    task automatic check_frames(input int n, input string name);
        int unsigned guard = 0;
        logic [7:0]  e;
        while (rx_q.size() < rd_idx + n && guard < (n + 2) * F + 100) begin
            @(negedge sysclk);
            guard++;
        end
        tests++;
        if (rx_q.size() < rd_idx + n) begin
            fails++;
            $display("FAIL %s frame_count: got %0d, required %0d", name, rx_q.size() - rd_idx, n);
        end
        for (int i = 0; i < n && rd_idx < rx_q.size(); i++) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s frame%0d: got %02h, required none", name, i, rx_q[rd_idx].data);
            end else begin
                e = exp_q.pop_front();
                if (!rx_q[rd_idx].ok || rx_q[rd_idx].data !== e) begin
                    fails++;
                    $display("FAIL %s frame%0d: got %02h (shape_ok=%0b), required %02h",
                             name, i, rx_q[rd_idx].data, rx_q[rd_idx].ok, e);
                end
            end
            rd_idx++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sysclk);
        tests++;
        if (PC_Uart_txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b, required 1", PC_Uart_txd); end
        tests++;
        if (tx_status !== 1'b1) begin fails++; $display("FAIL reset_status: got %b, required 1", tx_status); end
        tests++;
        if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b, required 0", fifo_full); end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_single();
        int unsigned p;
        write_burst(8'hA5, 1, 1, p);
        tests++;
        if (tx_status !== 1'b0 || PC_Uart_txd !== 1'b1) begin
            fails++;
            $display("FAIL single_push_edge: got status=%b txd=%b, required status=0 txd=1", tx_status, PC_Uart_txd);
        end
        wait_until(p + 1);
        tests++;
        if (PC_Uart_txd !== 1'b0) begin fails++; $display("FAIL single_start_latency: got %b, required 0", PC_Uart_txd); end
        wait_until(p + F);
        tests++;
        if (tx_status !== 1'b0) begin fails++; $display("FAIL single_busy_in_stop: got %b, required 0", tx_status); end
        wait_until(p + 1 + F);
        tests++;
        if (tx_status !== 1'b1) begin fails++; $display("FAIL single_idle_after_frame: got %b, required 1", tx_status); end
        check_frames(1, "single");
    endtask

    task automatic test_back_to_back();
        int unsigned p;
        do_reset();
        tx_enable = 1'b1; tx_data = 8'h00; exp_q.push_back(8'h00);
        @(negedge sysclk);
        p = cyc;
        tx_data = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge sysclk);
        tx_enable = 1'b0;
        check_frames(2, "b2b");
        tests++;
        if (rd_idx < 2 || rx_q[rd_idx-1].start - rx_q[rd_idx-2].start != F) begin
            fails++;
            $display("FAIL b2b_gap: got %0d, required %0d",
                     (rd_idx < 2) ? 0 : int'(rx_q[rd_idx-1].start - rx_q[rd_idx-2].start), F);
        end
        tests++;
        if (rd_idx < 2 || rx_q[rd_idx-2].start != p + 1) begin
            fails++;
            $display("FAIL b2b_first_start: got %0d, required %0d",
                     (rd_idx < 2) ? 0 : int'(rx_q[rd_idx-2].start), p + 1);
        end
    endtask

    task automatic test_overflow();
        int unsigned p;
        do_reset();
        write_burst(8'h01, 9, 9, p);
        tests++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_ninth_accepted: got full=%b ovf=%b, required full=1 ovf=0", fifo_full, overflow);
        end
        tx_enable = 1'b1; tx_data = 8'hEE;
        @(negedge sysclk);
        tx_enable = 1'b0;
        tests++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_tenth_dropped: got full=%b ovf=%b, required full=1 ovf=1", fifo_full, overflow);
        end
        check_frames(9, "ovf");
        repeat (F + 10) @(negedge sysclk);
        tests++;
        if (rx_q.size() != rd_idx) begin fails++; $display("FAIL ovf_extra_frame: got %0d, required 0", rx_q.size() - rd_idx); end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_reset_midframe();
        int unsigned p;
        bit          bad = 1'b0;
        do_reset();
        write_burst(8'h3C, 1, 1, p);
        tx_enable = 1'b1; tx_data = 8'h5A;
        @(negedge sysclk);
        tx_enable = 1'b0;
        wait_until(p + 1 + B * (1 + 3) + 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        tests++;
        if (PC_Uart_txd !== 1'b1 || tx_status !== 1'b1 || fifo_full !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_data: got txd=%b status=%b full=%b, required 1 1 0", PC_Uart_txd, tx_status, fifo_full);
        end
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        repeat (3 * F) begin
            @(negedge sysclk);
            if (PC_Uart_txd !== 1'b1 || tx_status !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad || rx_q.size() != rd_idx) begin
            fails++;
            $display("FAIL rst_no_resume: got activity=%b frames=%0d, required 0 0", bad, rx_q.size() - rd_idx);
        end
        // Second abort lands in the start bit, where the line is low.
        write_burst(8'h81, 1, 0, p);
        wait_until(p + 2);
        reset = 1'b1;
        #1;
        tests++;
        if (PC_Uart_txd !== 1'b1) begin fails++; $display("FAIL rst_async_start: got %b, required 1", PC_Uart_txd); end
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_push_pop();
        int unsigned p;
        do_reset();
        write_burst(8'h40, 8, 8, p);
        tests++;
        if (fifo_full !== 1'b0) begin fails++; $display("FAIL pp_seven_held: got %b, required 0", fifo_full); end
        wait_until(p + F);
        tx_enable = 1'b1; tx_data = 8'hC1; exp_q.push_back(8'hC1);
        @(negedge sysclk);
        tests++;
        if (fifo_full !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL pp_one_free: got full=%b ovf=%b, required 0 0", fifo_full, overflow);
        end
        tx_data = 8'hC2; exp_q.push_back(8'hC2);
        @(negedge sysclk);
        tx_enable = 1'b0;
        tests++;
        if (fifo_full !== 1'b1) begin fails++; $display("FAIL pp_now_full: got %b, required 1", fifo_full); end
        wait_until(p + 2 * F);
        tx_enable = 1'b1; tx_data = 8'hC3; exp_q.push_back(8'hC3);
        @(negedge sysclk);
        tx_enable = 1'b0;
        tests++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL pp_full_with_pop: got full=%b ovf=%b, required 1 0", fifo_full, overflow);
        end
        check_frames(11, "pp");
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL pp_no_overflow: got %b, required 0", overflow); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int unsigned p;
        do_reset();
        write_burst(8'h07, 1, 1, p);
        wait_until(p + 1 + B * 9 + 1);
        tests++;
        if (PC_Uart_txd !== 1'b1) begin fails++; $display("FAIL parity_bit: got %b, required 1", PC_Uart_txd); end
        wait_until(p + 44);
        tests++;
        if (tx_status !== 1'b0) begin fails++; $display("FAIL parity_len_busy: got %b, required 0", tx_status); end
        wait_until(p + 45);
        tests++;
        if (tx_status !== 1'b1) begin fails++; $display("FAIL parity_len_idle: got %b, required 1", tx_status); end
        check_frames(1, "parity");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_push_pop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Transmit stage fed by the memory-mapped peripheral block.
- Each byte the CPU writes to the UART TX register (tx_data plus a one-cycle tx_enable strobe) is queued in a small FIFO.
- Queued bytes are serialised onto PC_Uart_txd as 8N1 frames, LSB first.
- A write arriving while an earlier byte is still on the wire is therefore not lost. Status outputs feed the peripheral's UART_CON readback.

Parameters:
- BAUD_DIV, 10416, sysclk cycles per bit (100 MHz / 9600); legal range 2..65535.
- FIFO_DEPTH, 8, queue entries; power of two, minimum 2.

Ports:
- sysclk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- tx_data  in  8  byte to enqueue; sampled when tx_enable=1.
- tx_enable  in  1  one-cycle write strobe.
- tx_status  out  1  1 = idle: FIFO empty and serialiser in IDLE.
- fifo_full  out  1  1 = FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky; set when a write is dropped.
- PC_Uart_txd  out  1  serial line, registered; idle-high.

Behaviour:
- Reset values: PC_Uart_txd=1, tx_status=1, fifo_full=0, overflow=0, FIFO pointers and count=0, FSM=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame and forces the line high immediately; queued bytes are discarded.
- Push: on a rising edge with tx_enable=1, tx_data is written if the FIFO is not full, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set.
  - overflow is cleared only by reset.
- Pointers: wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide, so full and empty are unambiguous.
- Simultaneous push and pop leaves the count unchanged.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, set txd=0, go to START. Otherwise hold txd=1.
  - START: hold 0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0] for BAUD_DIV cycles, then shift right. After bit 7 go to STOP.
  - STOP: hold 1 for BAUD_DIV cycles. At the end of the stop bit, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a write on edge N into an empty FIFO drives txd low on edge N+2.
  - Edge N+1: count becomes 1.
  - Edge N+2: IDLE pops the byte and drives txd=0.
- Frame length: exactly 10*BAUD_DIV cycles from txd falling to the end of the stop bit.
- Baud counter: counts 0..BAUD_DIV-1, resets on every bit transition; no drift between bits.
- tx_status is combinational from registered state: (FSM==IDLE) && (count==0). It drops on edge N+1 after a write into an idle block.
- The block never back-pressures; the CPU polls fifo_full or tx_status.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: adds state PARITY between DATA and STOP, driving the even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles. The frame becomes 11*BAUD_DIV cycles.
- Undefined: no PARITY state; frame is 8N1 as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4).
  - Default BAUD_DIV constant.
  - Frame bit counts.
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, full, empty and count.
- The serialiser FSM stays in the top module.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=8):
- Reset, then single write 0xA5 on edge N.
  - txd=0 on N+2.
  - Bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop high.
  - tx_status returns to 1 at N+2+40.
- Write 0x00 and 0xFF on consecutive cycles.
  - Two frames back to back.
  - Second start bit begins immediately after the first stop bit; no idle cycle.
- Nine writes in nine consecutive cycles.
  - The first byte is popped before the ninth write, so the ninth is accepted: fifo_full=1, overflow=0.
  - A tenth write is dropped and overflow=1.
  - Ten frames minus the one dropped are transmitted, in order.
- Assert reset in the middle of the DATA bit 3 of 0x3C.
  - txd=1 in the same cycle.
  - tx_status=1; no further frame after release.
- Write when one entry remains free, with a pop on the same edge.
  - Byte accepted; count unchanged; overflow stays 0.
- With UART_TX_PARITY_EN, write 0x07.
  - Parity bit = 1 after data; frame length is 44 cycles.
